cpu_prog_loader: RTL and testbench
==================================

CPU_PROG_LOADER -- requirements
Module: cpu_prog_loader

Interface
REQ-001 The clock SHALL be clk (input, 1 bit), the single clock; all state updates on its rising edge.
REQ-002 The reset SHALL be rst_n (input, 1 bit), asynchronous, active-low.
REQ-003 ena  input  1  tile enable; low freezes all state and forces mem_we=0.
REQ-004 load_en  input  1  asynchronous host request to enter program-load mode.
REQ-005 data_strobe  input  1  asynchronous host byte strobe; a rising edge means data_in is valid.
REQ-006 data_in  input  8  program byte; host holds it stable from 1 clk before the strobe rise until the strobe falls.
REQ-007 cpu_halted  input  1  CPU core has executed HALT.
REQ-008 mem_we  output  1  one-cycle write pulse to the 16x8 program memory.
REQ-009 mem_addr  output  4  write address.
REQ-010 mem_wdata  output  8  write data.
REQ-011 cpu_run  output  1  releases the CPU core; CPU held in reset while low.
REQ-012 byte_count  output  5  bytes written in the current load, 0..16.
REQ-013 loader_busy  output  1  high in LOAD.
REQ-014 overflow  output  1  sticky: a strobe arrived with 16 bytes already written.

Function
REQ-015 load_en and data_strobe SHALL each pass through a two-flop synchronizer; data_in SHALL be delayed by two flops so it aligns with the synchronized strobe.
REQ-016 A strobe edge SHALL be detected as s2 & ~s3, using a third flop s3; each rising edge yields exactly one detection, however long the strobe stays high.
REQ-017 States SHALL be IDLE, LOAD, RUN and HALTED; all transitions are registered.
REQ-018 IDLE->LOAD when synced load_en=1; on entry, byte_count:=0, mem_addr:=0 and overflow:=0.
REQ-019 In LOAD, each detection with byte_count<16 SHALL register mem_we=1, mem_wdata=aligned data_in and mem_addr=byte_count[3:0]; byte_count increments in the same edge.
REQ-020 Strobe-to-write latency SHALL be 3 clk rising edges after the edge at which data_strobe is first sampled high; mem_we is high for exactly one cycle.
REQ-021 A detection with byte_count=16 SHALL cause no write and SHALL set overflow; the state remains LOAD.
REQ-022 In LOAD, when synced load_en=0: go to RUN if byte_count>0, otherwise go to IDLE.
REQ-023 A detection in the same cycle as load_en falling SHALL still be written before the transition.
REQ-024 RUN SHALL assert cpu_run=1; RUN->HALTED when cpu_halted=1; RUN->LOAD when synced load_en=1, with cpu_run dropped in that edge.
REQ-025 HALTED SHALL drive cpu_run=0; HALTED->LOAD on load_en=1 and HALTED->RUN on a strobe detection (restart); other detections outside LOAD are ignored.
REQ-026 mem_addr SHALL hold its last value between writes; byte_count saturates at 16 and never wraps.
REQ-027 When ena=0, all registers hold except the synchronizer flops, which keep sampling; mem_we=0.

Reset
REQ-028 While rst_n=0: state=IDLE; mem_we=0, mem_addr=0, mem_wdata=0, byte_count=0, cpu_run=0, loader_busy=0, overflow=0, and all synchronizer flops=0.
REQ-029 A reset assertion mid-LOAD or mid-RUN SHALL abort immediately; a write in flight is dropped.

Structure
REQ-030 A shared package cpu_pkg SHALL hold the state enum loader_state_t, PROG_DEPTH=16, ADDR_W=4 and DATA_W=8.
REQ-031 One sub-module, sync2 (a parameterless 1-bit two-flop synchronizer with async active-low reset), SHALL be instantiated for load_en and for data_strobe.
REQ-032 The memory array SHALL NOT be inside this block; the block drives the write port only.

Verification
REQ-033 load_en=1, then strobes with data 0x11, 0x22, 0x33, then load_en=0 -> writes addr0=0x11, addr1=0x22, addr2=0x33, each 3 edges after its strobe; byte_count=3; then cpu_run=1.
REQ-034 17 strobes in LOAD -> 16 writes to addr 0..15, byte_count=16, overflow=1, no 17th mem_we.
REQ-035 load_en pulsed with no strobes -> returns to IDLE, cpu_run stays 0.
REQ-036 In RUN, cpu_halted=1 -> HALTED with cpu_run=0; then one strobe -> RUN with cpu_run=1; then load_en=1 -> LOAD with byte_count=0.
REQ-037 Strobe held high for 20 cycles -> exactly one mem_we pulse.
REQ-038 rst_n low for 1 cycle after the 5th byte in LOAD -> all outputs at reset values immediately; no further writes until a new load_en.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and sizes for the CPU program loader.
package cpu_pkg;
    localparam int PROG_DEPTH = 16;
    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 8;
    localparam int CNT_W      = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_HALTED
    } loader_state_t;
endpackage

// File: rtl/sync2.sv
// 1-bit two-flop synchronizer with asynchronous active-low reset.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/cpu_prog_loader.sv
// Host-driven program loader: synchronizes a byte strobe interface and writes
// up to 16 bytes into the program memory, then releases the CPU core.
module cpu_prog_loader
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              load_en,
    input  logic              data_strobe,
    input  logic [DATA_W-1:0] data_in,
    input  logic              cpu_halted,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_run,
    output logic [CNT_W-1:0]  byte_count,
    output logic              loader_busy,
    output logic              overflow
);
    logic              ld_s, stb_s2, stb_s3, det_q;
    logic [DATA_W-1:0] d1, d2, det_data;

    loader_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d, ovf_q, ovf_d;

    sync2 u_sync_load (.clk(clk), .rst_n(rst_n), .d(load_en),     .q(ld_s));
    sync2 u_sync_stb  (.clk(clk), .rst_n(rst_n), .d(data_strobe), .q(stb_s2));

    // Edge detect is registered once more, with its data, so the write lands
    // three edges after the strobe is first sampled. This front end ignores ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_s3   <= 1'b0;
            d1       <= '0;
            d2       <= '0;
            det_q    <= 1'b0;
            det_data <= '0;
        end else begin
            stb_s3   <= stb_s2;
            d1       <= data_in;
            d2       <= d1;
            det_q    <= stb_s2 & ~stb_s3;
            det_data <= d2;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ovf_d   = ovf_q;
        we_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ld_s) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    addr_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (det_q) begin
                    if (cnt_q < CNT_W'(PROG_DEPTH)) begin
                        we_d    = 1'b1;
                        wdata_d = det_data;
                        addr_d  = cnt_q[ADDR_W-1:0];
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                // a byte detected alongside load_en falling still counts
                if (!ld_s)
                    state_d = (cnt_d != '0) ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                if (ld_s) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    addr_d  = '0;
                    ovf_d   = 1'b0;
                end else if (cpu_halted) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (ld_s) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    addr_d  = '0;
                    ovf_d   = 1'b0;
                end else if (det_q) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            ovf_q   <= ovf_d;
        end else begin
            // clear so a pending pulse cannot reappear when ena returns
            we_q <= 1'b0;
        end
    end

    assign mem_we      = we_q & ena;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign byte_count  = cnt_q;
    assign overflow    = ovf_q;
    assign cpu_run     = (state_q == ST_RUN);
    assign loader_busy = (state_q == ST_LOAD);
endmodule

// File: tb/tb_cpu_prog_loader.sv
// Bench for cpu_prog_loader: directed scenarios plus randomized traffic against
// a delay-history reference model, compared every cycle.
module tb_cpu_prog_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       load_en = 1'b0;
    logic       data_strobe = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       cpu_halted = 1'b0;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_run;
    logic [4:0] byte_count;
    logic       loader_busy;
    logic       overflow;

    cpu_prog_loader dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .load_en(load_en),
        .data_strobe(data_strobe), .data_in(data_in), .cpu_halted(cpu_halted),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_run(cpu_run), .byte_count(byte_count), .loader_busy(loader_busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: inputs are kept as histories of edge samples; the loader
    // sees load_en two edges late and a strobe rise (with its byte) three late.
    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_HALT = 3;
    int         m_st = M_IDLE, m_cnt = 0, m_addr = 0, m_wdata = 0;
    bit         m_we = 1'b0, m_ovf = 1'b0;
    logic [1:0] ld_h = '0;
    logic [3:0] st_h = '0;
    logic [7:0] dat_h [4];
    bit         ld_now, det_now;
    logic [7:0] dat_now;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = M_IDLE; m_cnt = 0; m_addr = 0; m_wdata = 0; m_we = 0; m_ovf = 0;
            ld_h = '0; st_h = '0;
            foreach (dat_h[i]) dat_h[i] = 8'h00;
        end else begin
            ld_now  = ld_h[1];
            det_now = st_h[2] && !st_h[3];
            dat_now = dat_h[2];
            ld_h = {ld_h[0], load_en};
            st_h = {st_h[2:0], data_strobe};
            dat_h[3] = dat_h[2]; dat_h[2] = dat_h[1]; dat_h[1] = dat_h[0]; dat_h[0] = data_in;
            m_we = 0;
            if (ena) begin
                case (m_st)
                    M_IDLE: if (ld_now) begin m_st = M_LOAD; m_cnt = 0; m_addr = 0; m_ovf = 0; end
                    M_LOAD: begin
                        if (det_now && m_cnt == 16) m_ovf = 1;
                        else if (det_now) begin
                            m_we = 1; m_addr = m_cnt; m_wdata = dat_now; m_cnt++;
                        end
                        if (!ld_now) m_st = (m_cnt > 0) ? M_RUN : M_IDLE;
                    end
                    M_RUN: begin
                        if (ld_now) begin m_st = M_LOAD; m_cnt = 0; m_addr = 0; m_ovf = 0; end
                        else if (cpu_halted) m_st = M_HALT;
                    end
                    default: begin
                        if (ld_now) begin m_st = M_LOAD; m_cnt = 0; m_addr = 0; m_ovf = 0; end
                        else if (det_now) m_st = M_RUN;
                    end
                endcase
            end
        end
    end

    int         n_vec = 0, n_bad = 0;
    int         we_cnt = 0, we_cyc = 0;
    logic [7:0] last_wdata = 8'h00;
    logic [7:0] mem_img [16];
    bit         busy_seen = 0, run_seen = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic compare_all();
        chk("mem_we",      int'(mem_we),      int'(m_we && ena));
        chk("mem_addr",    int'(mem_addr),    m_addr);
        chk("mem_wdata",   int'(mem_wdata),   m_wdata);
        chk("byte_count",  int'(byte_count),  m_cnt);
        chk("overflow",    int'(overflow),    int'(m_ovf));
        chk("cpu_run",     int'(cpu_run),     int'(m_st == M_RUN));
        chk("loader_busy", int'(loader_busy), int'(m_st == M_LOAD));
        if (mem_we) begin
            we_cnt++; we_cyc = cyc; last_wdata = mem_wdata; mem_img[mem_addr] = mem_wdata;
        end
        if (loader_busy) busy_seen = 1;
        if (cpu_run) run_seen = 1;
    endtask

    // Every clock passes through here, so the model compare runs every cycle.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            compare_all();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit chk_lat);
        int e0;
        data_in = b;
        tick(1);
        data_strobe = 1'b1;
        tick(1);
        e0 = cyc;
        tick(2);
        data_strobe = 1'b0;
        tick(3);
        if (chk_lat) begin
            chk("write_latency", we_cyc - e0, 3);
            chk("write_byte", int'(last_wdata), int'(b));
        end
    endtask

    int  base;
    bit  stb_r;

    initial begin
        foreach (mem_img[i]) mem_img[i] = 8'h00;
        tick(3);
        chk("rst_busy", int'(loader_busy), 0);
        chk("rst_count", int'(byte_count), 0);
        rst_n = 1'b1;
        tick(2);

        // three-byte load, then release
        load_en = 1'b1;
        tick(4);
        chk("load_entered", int'(loader_busy), 1);
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        send_byte(8'h33, 1);
        load_en = 1'b0;
        tick(4);
        chk("img0", int'(mem_img[0]), 8'h11);
        chk("img1", int'(mem_img[1]), 8'h22);
        chk("img2", int'(mem_img[2]), 8'h33);
        chk("count3", int'(byte_count), 3);
        chk("run_after_load", int'(cpu_run), 1);

        // halt, restart by strobe, reload
        cpu_halted = 1'b1;
        tick(1);
        cpu_halted = 1'b0;
        tick(2);
        chk("halted_run", int'(cpu_run), 0);
        base = we_cnt;
        send_byte(8'h55, 0);
        chk("restart_run", int'(cpu_run), 1);
        chk("restart_nowrite", we_cnt - base, 0);
        load_en = 1'b1;
        tick(4);
        chk("reload_busy", int'(loader_busy), 1);
        chk("reload_count", int'(byte_count), 0);

        // 17 bytes: the last one overflows
        base = we_cnt;
        for (int i = 0; i < 17; i++) send_byte(8'(i * 7 + 3), 0);
        chk("ovf_writes", we_cnt - base, 16);
        chk("ovf_count", int'(byte_count), 16);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_img0", int'(mem_img[0]), 3);
        chk("ovf_img15", int'(mem_img[15]), 108);
        load_en = 1'b0;
        tick(4);
        chk("ovf_run", int'(cpu_run), 1);

        // long strobe gives a single write
        load_en = 1'b1;
        tick(4);
        chk("long_ovf_clr", int'(overflow), 0);
        base = we_cnt;
        data_in = 8'h5A;
        tick(1);
        data_strobe = 1'b1;
        tick(20);
        data_strobe = 1'b0;
        tick(5);
        chk("long_pulses", we_cnt - base, 1);
        chk("long_img0", int'(mem_img[0]), 8'h5A);

        // reset mid-load with a byte in flight
        for (int i = 0; i < 4; i++) send_byte(8'(8'hA1 + i), 0);
        chk("pre_rst_count", int'(byte_count), 5);
        data_in = 8'hEE;
        tick(1);
        data_strobe = 1'b1;
        tick(2);
        rst_n = 1'b0;
        load_en = 1'b0;
        #1;
        chk("arst_we", int'(mem_we), 0);
        chk("arst_addr", int'(mem_addr), 0);
        chk("arst_wdata", int'(mem_wdata), 0);
        chk("arst_count", int'(byte_count), 0);
        chk("arst_run", int'(cpu_run), 0);
        chk("arst_busy", int'(loader_busy), 0);
        chk("arst_ovf", int'(overflow), 0);
        tick(1);
        rst_n = 1'b1;
        base = we_cnt;
        tick(2);
        data_strobe = 1'b0;
        send_byte(8'h77, 0);
        tick(2);
        chk("post_rst_nowrite", we_cnt - base, 0);
        chk("post_rst_busy", int'(loader_busy), 0);

        // empty load returns to idle
        busy_seen = 0;
        run_seen = 0;
        load_en = 1'b1;
        tick(2);
        load_en = 1'b0;
        tick(6);
        chk("empty_busy_seen", int'(busy_seen), 1);
        chk("empty_no_run", int'(run_seen), 0);
        chk("empty_idle", int'(loader_busy), 0);

        // randomized traffic
        stb_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) load_en = ~load_en;
            if (stb_r) begin
                if ($urandom_range(0, 2) == 0) stb_r = 0;
            end else if ($urandom_range(0, 3) == 0) begin
                stb_r = 1;
            end else begin
                data_in = 8'($urandom);
            end
            data_strobe = stb_r;
            cpu_halted = ($urandom_range(0, 15) == 0);
            ena = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
            end
            tick(1);
        end
        ena = 1'b1;
        tick(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
